// File: rtl/gpio_bank_pkg.sv
// Shared register map, bus request struct and width helper for the GPIO bank.
package gpio_bank_pkg;

    localparam logic [3:0] ADDR_IN       = 4'h0;
    localparam logic [3:0] ADDR_OUT      = 4'h1;
    localparam logic [3:0] ADDR_OUT_SET  = 4'h2;
    localparam logic [3:0] ADDR_OUT_CLR  = 4'h3;
    localparam logic [3:0] ADDR_OUT_TGL  = 4'h4;
    localparam logic [3:0] ADDR_IEN_RISE = 4'h5;
    localparam logic [3:0] ADDR_IEN_FALL = 4'h6;
    localparam logic [3:0] ADDR_IRQ_STAT = 4'h7;

    typedef struct packed {
        logic        we;
        logic        re;
        logic [3:0]  addr;
        logic [31:0] di;
    } gpio_req_t;

    // Minimum 1 so a degenerate parameter still yields a legal vector.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One input bit: flop synchroniser, stability counter, and single-cycle edge pulses.
module gpio_debounce
    import gpio_bank_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic OPB_CLK,
    input  logic OPB_RST_N,
    input  logic pin,
    output logic deb,
    output logic rise,
    output logic fall
);

    localparam int CW = clog2(DEB_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   sample;
    logic                   hit;

    assign sample = sync[SYNC_STAGES-1];
    // The DEB_CYCLES-th consecutive mismatching cycle commits the new level.
    assign hit    = (sample != deb) && (cnt == CW'(DEB_CYCLES - 1));
    assign rise   = hit & sample;
    assign fall   = hit & ~sample;

    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            sync <= '0;
            cnt  <= '0;
            deb  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pin};
            if (sample == deb) begin
                cnt <= '0;
            end else if (hit) begin
                deb <= sample;
                cnt <= '0;
            end else if (cnt != CW'(DEB_CYCLES)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank on the OPB register bus: debounced inputs with edge IRQs, set/clear/toggle outputs.
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int          NUM_IN      = 32,
    parameter int          NUM_OUT     = 32,
    parameter int          SYNC_STAGES = 2,
    parameter int          DEB_CYCLES  = 16,
    parameter logic [31:0] OUT_RST_VAL = '0
) (
    input  logic               OPB_CLK,
    input  logic               OPB_RST_N,
    input  logic [3:0]         GPIO_ADDR,
    input  logic [31:0]        GPIO_DI,
    input  logic               GPIO_WE,
    input  logic               GPIO_RE,
    output logic [31:0]        GPIO_DO,
    input  logic [NUM_IN-1:0]  GPIO_IN,
    output logic [NUM_OUT-1:0] GPIO_OUT,
    output logic               GPIO_IRQ
);

    gpio_req_t          req;
    logic [NUM_IN-1:0]  deb, rise, fall;
    logic [NUM_IN-1:0]  ien_rise, ien_fall, irq_stat, w1c;
    logic [NUM_OUT-1:0] out_r, dout;
    logic [NUM_IN-1:0]  din;
    logic [31:0]        rd;
    logic               unused_di;

    assign req       = '{we: GPIO_WE, re: GPIO_RE, addr: GPIO_ADDR, di: GPIO_DI};
    assign dout      = req.di[NUM_OUT-1:0];
    assign din       = req.di[NUM_IN-1:0];
    assign unused_di = ^req.di;
    assign w1c       = (req.we && req.addr == ADDR_IRQ_STAT) ? din : '0;
    assign GPIO_OUT  = out_r;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_in
        gpio_debounce #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .OPB_CLK  (OPB_CLK),
            .OPB_RST_N(OPB_RST_N),
            .pin      (GPIO_IN[g]),
            .deb      (deb[g]),
            .rise     (rise[g]),
            .fall     (fall[g])
        );
    end

    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            out_r    <= OUT_RST_VAL[NUM_OUT-1:0];
            ien_rise <= '0;
            ien_fall <= '0;
        end else if (req.we) begin
            case (req.addr)
                ADDR_OUT:      out_r    <= dout;
                ADDR_OUT_SET:  out_r    <= out_r | dout;
                ADDR_OUT_CLR:  out_r    <= out_r & ~dout;
                ADDR_OUT_TGL:  out_r    <= out_r ^ dout;
                ADDR_IEN_RISE: ien_rise <= din;
                ADDR_IEN_FALL: ien_fall <= din;
                default: ;
            endcase
        end
    end

    // Hardware set is OR'd after the W1C mask so a coincident edge survives.
    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N) begin
            irq_stat <= '0;
            GPIO_IRQ <= 1'b0;
        end else begin
            irq_stat <= (irq_stat & ~w1c) | (rise & ien_rise) | (fall & ien_fall);
            GPIO_IRQ <= |irq_stat;
        end
    end

    always_comb begin
        rd = '0;
        case (req.addr)
            ADDR_IN:       rd[NUM_IN-1:0]  = deb;
            ADDR_OUT:      rd[NUM_OUT-1:0] = out_r;
            ADDR_IEN_RISE: rd[NUM_IN-1:0]  = ien_rise;
            ADDR_IEN_FALL: rd[NUM_IN-1:0]  = ien_fall;
            ADDR_IRQ_STAT: rd[NUM_IN-1:0]  = irq_stat;
            default: ;
        endcase
    end

    always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
        if (!OPB_RST_N)  GPIO_DO <= '0;
        else if (req.re) GPIO_DO <= rd;
    end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: register ops, debounce timing, edge IRQs, async reset.
module tb_gpio_bank;

    logic        OPB_CLK = 1'b0;
    logic        OPB_RST_N = 1'b0;
    logic [3:0]  GPIO_ADDR = '0;
    logic [31:0] GPIO_DI = '0;
    logic        GPIO_WE = 1'b0;
    logic        GPIO_RE = 1'b0;
    logic [31:0] GPIO_DO;
    logic [3:0]  GPIO_IN = '0;
    logic [7:0]  GPIO_OUT;
    logic        GPIO_IRQ;

    int total = 0;
    int bad = 0;
    logic [31:0] rv;

    gpio_bank #(
        .NUM_IN     (4),
        .NUM_OUT    (8),
        .SYNC_STAGES(2),
        .DEB_CYCLES (16),
        .OUT_RST_VAL(32'h5)
    ) dut (
        .OPB_CLK  (OPB_CLK),
        .OPB_RST_N(OPB_RST_N),
        .GPIO_ADDR(GPIO_ADDR),
        .GPIO_DI  (GPIO_DI),
        .GPIO_WE  (GPIO_WE),
        .GPIO_RE  (GPIO_RE),
        .GPIO_DO  (GPIO_DO),
        .GPIO_IN  (GPIO_IN),
        .GPIO_OUT (GPIO_OUT),
        .GPIO_IRQ (GPIO_IRQ)
    );

    always #5 OPB_CLK = ~OPB_CLK;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge OPB_CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        GPIO_ADDR = a; GPIO_DI = d; GPIO_WE = 1'b1;
        tick();
        GPIO_WE = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        GPIO_ADDR = a; GPIO_RE = 1'b1;
        tick();
        GPIO_RE = 1'b0;
        d = GPIO_DO;
    endtask

    initial begin
        // 1) reset state
        tick(2);
        chk("rst_out", 32'(GPIO_OUT), 32'h05);
        chk("rst_do",  GPIO_DO, 32'h0);
        chk("rst_irq", 32'(GPIO_IRQ), 32'h0);
        OPB_RST_N = 1'b1;
        rd(4'h0, rv); chk("rst_in", rv, 32'h0);

        // 2) output register ops
        wr(4'h1, 32'hF0); wr(4'h2, 32'h01); wr(4'h3, 32'h10); wr(4'h4, 32'h03);
        chk("out_ops_pin", 32'(GPIO_OUT), 32'hE2);
        rd(4'h1, rv); chk("out_ops_rd", rv, 32'hE2);
        GPIO_ADDR = 4'h1; GPIO_DI = 32'h33; GPIO_WE = 1'b1; GPIO_RE = 1'b1;
        tick();
        GPIO_WE = 1'b0; GPIO_RE = 1'b0;
        chk("rw_same_prewrite", GPIO_DO, 32'hE2);
        chk("rw_same_out", 32'(GPIO_OUT), 32'h33);
        wr(4'h9, 32'hFFFF_FFFF);
        rd(4'h9, rv); chk("unmapped_rd", rv, 32'h0);
        rd(4'h2, rv); chk("wo_rd", rv, 32'h0);
        chk("unmapped_wr", 32'(GPIO_OUT), 32'h33);
        wr(4'h1, 32'hFFFF_FFFF);
        rd(4'h1, rv); chk("out_upper_masked", rv, 32'hFF);

        // 3) 15-cycle glitch must be filtered
        GPIO_IN[0] = 1'b1; tick(15); GPIO_IN[0] = 1'b0;
        tick(25);
        rd(4'h0, rv); chk("glitch_in", rv, 32'h0);

        // 4) latency and rising-edge IRQ; DO shows IN one cycle late
        wr(4'h5, 32'h1);
        GPIO_ADDR = 4'h0; GPIO_RE = 1'b1;
        GPIO_IN[0] = 1'b1;
        tick(18);
        chk("lat_in_17", GPIO_DO, 32'h0);
        chk("irq_before", 32'(GPIO_IRQ), 32'h0);
        tick();
        chk("lat_in_18", GPIO_DO, 32'h1);
        chk("irq_assert", 32'(GPIO_IRQ), 32'h1);
        GPIO_RE = 1'b0;
        rd(4'h7, rv); chk("stat_rise", rv, 32'h1);
        wr(4'h7, 32'h1);
        tick();
        chk("irq_w1c", 32'(GPIO_IRQ), 32'h0);
        rd(4'h7, rv); chk("stat_w1c", rv, 32'h0);
        GPIO_IN[0] = 1'b0; tick(25);
        rd(4'h7, rv); chk("fall_disabled", rv, 32'h0);
        rd(4'h0, rv); chk("fall_in", rv, 32'h0);

        // falling edge on bit1, rise on bit1 not enabled
        wr(4'h6, 32'h2);
        GPIO_IN[1] = 1'b1; tick(25);
        rd(4'h7, rv); chk("rise1_disabled", rv, 32'h0);
        GPIO_IN[1] = 1'b0; tick(25);
        rd(4'h7, rv); chk("fall1_flag", rv, 32'h2);
        wr(4'h6, 32'h0);
        rd(4'h7, rv); chk("ien_clr_keeps", rv, 32'h2);
        wr(4'h7, 32'h2);
        rd(4'h7, rv); chk("fall1_w1c", rv, 32'h0);

        // 5) W1C coincident with hardware set: set wins
        GPIO_IN[0] = 1'b1;
        tick(17);
        GPIO_ADDR = 4'h7; GPIO_DI = 32'h1; GPIO_WE = 1'b1;
        tick();
        GPIO_WE = 1'b0;
        rd(4'h7, rv); chk("set_wins", rv, 32'h1);
        chk("irq_pre_rst", 32'(GPIO_IRQ), 32'h1);

        // 6) async reset mid-debounce
        wr(4'h1, 32'hFF);
        chk("out_ff", 32'(GPIO_OUT), 32'hFF);
        GPIO_IN[1] = 1'b1;
        tick(5);
        #3 OPB_RST_N = 1'b0;
        #1;
        chk("arst_out", 32'(GPIO_OUT), 32'h05);
        chk("arst_irq", 32'(GPIO_IRQ), 32'h0);
        chk("arst_do",  GPIO_DO, 32'h0);
        tick(2);
        OPB_RST_N = 1'b1;
        GPIO_ADDR = 4'h0; GPIO_RE = 1'b1;
        tick(18);
        chk("redeb_17", GPIO_DO, 32'h0);
        tick();
        chk("redeb_18", GPIO_DO, 32'h3);
        GPIO_RE = 1'b0;
        rd(4'h7, rv); chk("redeb_no_irq", rv, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
